// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory store path: size encodings,
// FSM state encodings and the lane-mask helper.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_CAPT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    CAPT  = ST_CAPT,
    WRITE = ST_WRITE,
    RESP  = ST_RESP
  } state_t;

  localparam logic [31:0] BYTE_LANE = 32'h0000_00FF;
  localparam logic [31:0] HALF_LANE = 32'h0000_FFFF;
  localparam logic [31:0] WORD_LANE = 32'hFFFF_FFFF;

  // Little-endian: byte lane k is bits [8k+7:8k], halfword lane is addr[1].
  function automatic logic [31:0] lane_mask(input logic [1:0] size,
                                            input logic [1:0] lo);
    logic [31:0] m;
    m = '0;
    case (size)
      SZ_BYTE: m = BYTE_LANE << {lo, 3'b000};
      SZ_HALF: m = HALF_LANE << {lo[1], 4'b0000};
      SZ_WORD: m = WORD_LANE;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_narrow_rmw_lane_merge.sv
// Combinational lane merge: narrows the store value into its lane of the old
// word and flags overflow (non-sign-extended upper bits) and misalignment.
module lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged,
  output logic        ovf,
  output logic        misalign
);

  logic [31:0] mask;
  logic [31:0] shifted;

  always_comb begin
    mask     = lane_mask(size, addr_lo);
    shifted  = '0;
    ovf      = 1'b0;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: begin
        shifted = data << {addr_lo, 3'b000};
        ovf     = data[31:8] != {24{data[7]}};
      end
      SZ_HALF: begin
        shifted  = data << {addr_lo[1], 4'b0000};
        ovf      = data[31:16] != {16{data[15]}};
        misalign = addr_lo[0];
      end
      SZ_WORD: begin
        shifted  = data;
        misalign = addr_lo != 2'b00;
      end
      default: misalign = 1'b1;
    endcase
    merged = (old_word & ~mask) | (shifted & mask);
  end

endmodule

// File: rtl/store_narrow_rmw.sv
// Store-path unit: narrows a register value to a byte/halfword/word lane and
// performs a read-modify-write on the synchronous-read word memory.
module store_narrow_rmw
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              rsp_valid,
  output logic              rsp_ovf,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [1:0]        size_q;
  logic [31:0]       old_q;
  logic              ovf_q;
  logic              err_q;

  logic [31:0] lm_data;
  logic [1:0]  lm_size;
  logic [1:0]  lm_lo;
  logic [31:0] merged;
  logic        ovf;
  logic        misalign;

  // One merge unit serves both phases: in IDLE it classifies the incoming
  // request, afterwards it merges the latched request into the captured word.
  always_comb begin
    if (state == IDLE) begin
      lm_data = req_data;
      lm_size = req_size;
      lm_lo   = req_addr[1:0];
    end else begin
      lm_data = data_q;
      lm_size = size_q;
      lm_lo   = addr_q[1:0];
    end
  end

  lane_merge u_lane_merge (
    .old_word (old_q),
    .data     (lm_data),
    .size     (lm_size),
    .addr_lo  (lm_lo),
    .merged   (merged),
    .ovf      (ovf),
    .misalign (misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
      old_q  <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            data_q <= req_data;
            size_q <= req_size;
            old_q  <= '0;
            err_q  <= misalign;
            ovf_q  <= ovf & ~misalign;
            if (misalign)              state <= RESP;
            else if (req_size == SZ_WORD) state <= WRITE;
            else                       state <= READ;
          end
        end
        READ:    state <= CAPT;
        CAPT: begin
          old_q <= mem_rd_data;
          state <= WRITE;
        end
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are gated by reset so nothing is issued during the reset cycle.
  always_comb begin
    req_ready   = ~reset & (state == IDLE);
    mem_rd_en   = ~reset & (state == READ);
    mem_wr_en   = ~reset & (state == WRITE);
    rsp_valid   = ~reset & (state == RESP);
    rsp_ovf     = rsp_valid & ovf_q;
    rsp_err     = rsp_valid & err_q;
    mem_wr_data = mem_wr_en ? merged : '0;
    mem_addr    = (mem_rd_en | mem_wr_en) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Directed bench for store_narrow_rmw with a word-memory model and a
// write/response scoreboard.
module tb_store_narrow_rmw;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        rsp_valid;
  logic        rsp_ovf;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [1:0]  rsp_q[$];
  logic [31:0] mem[16];

  store_narrow_rmw #(.ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_size    (req_size),
    .rsp_valid   (rsp_valid),
    .rsp_ovf     (rsp_ovf),
    .rsp_err     (rsp_err),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory; read data is garbage unless a read was strobed.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h1122_3344;
      mem[1] <= 32'hAABB_CCDD;
      mem[2] <= 32'h1234_5678;
      mem[5] <= 32'h5555_5555;
    end else if (mem_wr_en) begin
      mem[mem_addr[5:2]] <= mem_wr_data;
    end
    mem_rd_data <= mem_rd_en ? mem[mem_addr[5:2]] : $urandom;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe and response is matched against the queue.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      if (wr_q.size() == 0) chk("unexpected_write", 32'(mem_wr_en), 32'h0);
      else begin
        wr_exp_t e;
        e = wr_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wr_data, e.data);
      end
    end
    if (rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
      else begin
        logic [1:0] r;
        r = rsp_q.pop_front();
        chk("rsp_ovf", 32'(rsp_ovf), 32'(r[1]));
        chk("rsp_err", 32'(rsp_err), 32'(r[0]));
      end
    end
  end

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({tag, "_ready_timeout"}, 32'(req_ready), 32'h1);
  endtask

  // Strobe cycles are offsets from the accepting edge; 0 means never.
  task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic [31:0] exp_wd,
                       input logic exp_ovf, input logic exp_err,
                       input int rd_c, input int wr_c, input int rsp_c);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    wait_ready(tag);
    if (wr_c != 0) wr_q.push_back('{addr: a & 32'hFFFF_FFFC, data: exp_wd});
    rsp_q.push_back({exp_ovf, exp_err});
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      chk({tag, "_rd_en"},  32'(mem_rd_en), 32'(k == rd_c));
      chk({tag, "_wr_en"},  32'(mem_wr_en), 32'(k == wr_c));
      chk({tag, "_rsp"},    32'(rsp_valid), 32'(k == rsp_c));
      chk({tag, "_ready"},  32'(req_ready), 32'(k > rsp_c));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},   32'(req_ready), 32'h0);
    chk({tag, "_rd_en"},   32'(mem_rd_en), 32'h0);
    chk({tag, "_wr_en"},   32'(mem_wr_en), 32'h0);
    chk({tag, "_rsp"},     32'(rsp_valid), 32'h0);
    chk({tag, "_ovf"},     32'(rsp_ovf),   32'h0);
    chk({tag, "_err"},     32'(rsp_err),   32'h0);
    chk({tag, "_addr"},    mem_addr,       32'h0);
    chk({tag, "_wr_data"}, mem_wr_data,    32'h0);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_size  = '0;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("in_reset");
    @(negedge clk);
    reset = 1'b0;
    #1 chk("ready_after_reset", 32'(req_ready), 32'h1);

    store("byte_l1",  32'h8000_0001, 32'hFFFF_FF80, 2'b00, 32'h1122_8044, 1'b0, 1'b0, 1, 3, 4);
    store("byte_l3",  32'h8000_0007, 32'h0000_0180, 2'b00, 32'h80BB_CCDD, 1'b1, 1'b0, 1, 3, 4);
    store("half_hi",  32'h8000_000A, 32'h0000_7FFF, 2'b01, 32'h7FFF_5678, 1'b0, 1'b0, 1, 3, 4);
    store("half_mis", 32'h8000_000B, 32'h0000_7FFF, 2'b01, 32'h0,         1'b0, 1'b1, 0, 0, 1);
    store("word",     32'h8000_000C, 32'hDEAD_BEEF, 2'b10, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1, 2);
    store("size_ill", 32'h8000_000C, 32'h1234_5678, 2'b11, 32'h0,         1'b0, 1'b1, 0, 0, 1);
    store("word_mis", 32'h8000_000E, 32'h1234_5678, 2'b10, 32'h0,         1'b0, 1'b1, 0, 0, 1);
    store("half_ovf", 32'h8000_0008, 32'h0001_8000, 2'b01, 32'h7FFF_8000, 1'b1, 1'b0, 1, 3, 4);

    // Back-to-back byte stores with req_valid held high throughout.
    @(negedge clk);
    n = 0;
    req_valid = 1'b1;
    req_addr  = 32'h8000_0010;
    req_data  = 32'h0000_0012;
    req_size  = 2'b00;
    for (int c = 0; c < 15; c++) begin
      chk("b2b_ready", 32'(req_ready), 32'(c % 5 == 0));
      if (req_ready && req_valid) begin
        case (n)
          0: wr_q.push_back('{addr: 32'h8000_0010, data: 32'h0000_0012});
          1: wr_q.push_back('{addr: 32'h8000_0010, data: 32'h0000_3412});
          default: wr_q.push_back('{addr: 32'h8000_0010, data: 32'h0056_3412});
        endcase
        rsp_q.push_back(2'b00);
        n++;
      end
      @(posedge clk);
      #1;
      if (n >= 3) req_valid = 1'b0;
      else if (n == 1) begin
        req_addr = 32'h8000_0011;
        req_data = 32'h0000_0034;
      end else if (n == 2) begin
        req_addr = 32'h8000_0012;
        req_data = 32'h0000_0056;
      end
      @(negedge clk);
    end
    chk("b2b_accepts", 32'(n), 32'd3);
    chk("b2b_ready_end", 32'(req_ready), 32'h1);

    // Reset while the read data is being captured abandons the store.
    req_valid = 1'b1;
    req_addr  = 32'h8000_0015;
    req_data  = 32'h0000_0077;
    req_size  = 2'b00;
    wait_ready("rst");
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_in_read", 32'(mem_rd_en), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1 chk_all_zero("rst_capt");
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_release_ready", 32'(req_ready), 32'h1);
    chk("rst_release_wr", 32'(mem_wr_en), 32'h0);
    repeat (6) @(negedge clk);
    chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'h0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
